// File: rtl/turbo_param_loader_pkg.sv
// Shared turbo parameter definitions: loader FSM encoding and default table geometry.
// The defaults match the read-side parameter ROM so a loaded image equals the ROM file.
package turbo_param_loader_pkg;

    localparam int unsigned DefaultRamWidth    = 24;
    localparam int unsigned DefaultRamAddrBits = 10;
    localparam int unsigned DefaultNumEntries  = 565;
    localparam int unsigned HostWordWidth      = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StCheck  = 2'd2,
        StFinish = 2'd3
    } state_e;

    // True when any host bit above the entry field is set.
    function automatic logic has_format_error(input logic [HostWordWidth-1:0] word,
                                              input int unsigned entry_width);
        return (word >> entry_width) != '0;
    endfunction

endpackage

// File: rtl/turbo_param_loader_if.sv
// Host stream and parameter-table write port of the turbo parameter loader.
// The host side drives in_data/in_valid; the loader drives the rest.
interface turbo_param_loader_if
    import turbo_param_loader_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = DefaultRamWidth,
    parameter int unsigned RAM_ADDR_BITS = DefaultRamAddrBits
);

    logic [HostWordWidth-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     wr_en;
    logic [RAM_ADDR_BITS-1:0] write_address;
    logic [RAM_WIDTH-1:0]     write_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  write_address,
        input  write_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output write_address,
        output write_data
    );

endinterface

// File: rtl/param_wr_stage.sv
// Registered write port of the parameter table: a captured word appears on the
// write strobe exactly one cycle after it was accepted.
module param_wr_stage #(
    parameter int unsigned RAM_WIDTH     = 24,
    parameter int unsigned RAM_ADDR_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture,
    input  logic [RAM_ADDR_BITS-1:0] capture_addr,
    input  logic [RAM_WIDTH-1:0]     capture_data,
    output logic                     wr_en,
    output logic [RAM_ADDR_BITS-1:0] write_address,
    output logic [RAM_WIDTH-1:0]     write_data
);

    logic                     wr_en_q;
    logic [RAM_ADDR_BITS-1:0] write_address_q;
    logic [RAM_WIDTH-1:0]     write_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q         <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            wr_en_q <= capture;
            // Address/data hold their last value between writes.
            if (capture) begin
                write_address_q <= capture_addr;
                write_data_q    <= capture_data;
            end
        end
    end

    assign wr_en         = wr_en_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;

endmodule

// File: rtl/turbo_param_loader.sv
// Streams one parameter-table image from a host into the table, verifies an XOR
// trailer checksum and reports pass/fail with a done pulse.
module turbo_param_loader
    import turbo_param_loader_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = DefaultRamWidth,
    parameter int unsigned RAM_ADDR_BITS = DefaultRamAddrBits,
    // Must lie in 1..2**RAM_ADDR_BITS.
    parameter int unsigned NUM_ENTRIES   = DefaultNumEntries
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    turbo_param_loader_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                load_ok
);

    localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(NUM_ENTRIES - 1);

    state_e                   state_q;
    logic                     in_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     load_ok_q;
    logic                     err_q;
    logic [RAM_ADDR_BITS-1:0] cnt_q;
    logic [RAM_WIDTH-1:0]     csum_q;

    logic                     accept;
    logic                     wr_capture;
    logic                     fmt_err;
    logic [RAM_WIDTH-1:0]     entry;

    assign accept     = bus.in_valid & in_ready_q;
    assign wr_capture = accept & (state_q == StLoad);
    assign entry      = bus.in_data[RAM_WIDTH-1:0];
    assign fmt_err    = has_format_error(bus.in_data, RAM_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            csum_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StLoad;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        csum_q     <= '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        csum_q <= csum_q ^ entry;
                        if (fmt_err) begin
                            err_q <= 1'b1;
                        end
                        // Holding at the last index keeps the counter from wrapping.
                        if (cnt_q == LastIdx) begin
                            state_q <= StCheck;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        state_q    <= StFinish;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        load_ok_q  <= (entry == csum_q) & ~err_q;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    logic                     wr_en_w;
    logic [RAM_ADDR_BITS-1:0] write_address_w;
    logic [RAM_WIDTH-1:0]     write_data_w;

    param_wr_stage #(
        .RAM_WIDTH     (RAM_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_wr_stage (
        .clk           (clk),
        .rst           (rst),
        .capture       (wr_capture),
        .capture_addr  (cnt_q),
        .capture_data  (entry),
        .wr_en         (wr_en_w),
        .write_address (write_address_w),
        .write_data    (write_data_w)
    );

    assign bus.in_ready      = in_ready_q;
    assign bus.wr_en         = wr_en_w;
    assign bus.write_address = write_address_w;
    assign bus.write_data    = write_data_w;

    assign busy    = busy_q;
    assign done    = done_q;
    assign load_ok = load_ok_q;

endmodule

// File: doc/turbo_param_loader.md
TURBO_PARAM_LOADER -- requirements
Module: turbo_param_loader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 24, the width of one parameter-table entry in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 10, the parameter-table address width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 565, the number of table entries loaded per image.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a table load.
REQ-007 SHALL have port in_data, input, 32 bits: host word; entry value is in bits [RAM_WIDTH-1:0].
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: table write strobe.
REQ-011 SHALL have port write_address, output, RAM_ADDR_BITS bits: table write address.
REQ-012 SHALL have port write_data, output, RAM_WIDTH bits: table write data.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at load completion.
REQ-015 SHALL have port load_ok, output, 1 bit: status of the last completed load (1 = checksum matched and no format error).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CHECK, and FINISH.
REQ-017 IDLE: in_ready=0; start=1 -> LOAD; entry counter and checksum cleared to 0 on that transition.
REQ-018 LOAD: in_ready=1; a word is accepted only when in_valid and in_ready are both 1.
REQ-019 Each accepted LOAD word SHALL produce wr_en=1 exactly one cycle later, with write_address equal to the entry counter value at acceptance and write_data=in_data[RAM_WIDTH-1:0].
REQ-020 Each accepted LOAD word SHALL XOR in_data[RAM_WIDTH-1:0] into a RAM_WIDTH-bit running checksum and increment the entry counter.
REQ-021 When a word with counter value NUM_ENTRIES-1 is accepted, the FSM SHALL move to CHECK.
REQ-022 CHECK: in_ready=1; the next accepted word is the trailer, its bits [RAM_WIDTH-1:0] are compared with the checksum, no write is issued, and the FSM moves to FINISH.
REQ-023 Format error: any accepted LOAD word with nonzero in_data[31:RAM_WIDTH] SHALL set a sticky error flag; that word is still written.
REQ-024 FINISH lasts one cycle: done=1, load_ok=(checksum match AND no format error), then the FSM returns to IDLE.
REQ-025 load_ok SHALL hold its value until the next FINISH or reset.
REQ-026 busy SHALL be 1 in LOAD, CHECK, and FINISH, and 0 in IDLE.
REQ-027 A start pulse while busy=1 SHALL be ignored.
REQ-028 in_valid while in IDLE SHALL be ignored, with no write and no state change.
REQ-029 Gaps in in_valid SHALL stall the load with no write; there is no timeout.
REQ-030 The entry counter SHALL be RAM_ADDR_BITS wide, NUM_ENTRIES SHALL be at most 2**RAM_ADDR_BITS, and the counter never wraps.
REQ-031 wr_en SHALL be 0 in every cycle not covered by REQ-019.

Reset
REQ-032 Reset SHALL put the FSM in IDLE and set in_ready=0, wr_en=0, write_address=0, write_data=0, busy=0, done=0, load_ok=0, counter=0, checksum=0, and error flag=0.
REQ-033 Reset during LOAD or CHECK SHALL abort the load in the next cycle with no further writes and no done pulse; entries already written are not cleaned up.
REQ-034 rst and start in the same cycle: rst wins.

Structure
REQ-035 FSM state encoding and the default NUM_ENTRIES value SHALL live in a shared turbo parameter package.
REQ-036 The write-port register stage (wr_en, write_address, write_data) SHALL be one sub-module, param_wr_stage; everything else is a single module.
REQ-037 write_address and write_data SHALL match the width and addressing of the read-side parameter ROM, so that a loaded image equals the ROM file content.

Verification
REQ-038 Scenario 1: start, then 565 back-to-back words with value=index, then trailer = XOR of 0..564 -> 565 writes at addresses 0..564 with data=index, done after the trailer, load_ok=1.
REQ-039 Scenario 2: same stream with a wrong trailer (checksum^1) -> all 565 writes occur, done pulses, load_ok=0.
REQ-040 Scenario 3: word 10 = 0x01000005 -> address 10 written with 0x000005, load_ok=0 at done.
REQ-041 Scenario 4: in_valid toggling on every other cycle, plus a start pulse mid-load -> correct write sequence, start ignored, load_ok=1.
REQ-042 Scenario 5: rst asserted after 200 accepted words -> at most one pending write (address 199), then all outputs at reset values, no done; a fresh load then passes with load_ok=1.
